// File: rtl/intdiv_seq_pkg.sv
// Shared core definitions: integer ALU function codes and divider state encoding.
package bexkat1Def;

    typedef enum logic [3:0] {
        INT_ADD, INT_SUB, INT_MUL, INT_DIV, INT_MOD, INT_MULU, INT_DIVU, INT_MODU,
        INT_AND, INT_OR, INT_XOR, INT_COM, INT_NEG, INT_SHL, INT_SHR, INT_ASR
    } intfunc_t;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} intdiv_state_t;

    // Cycles beyond WIDTH for a full divide: FIXUP plus DONE
    localparam int unsigned INTDIV_EXTRA_CYCLES = 2;

    function automatic logic is_div_func(intfunc_t f);
        return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
    endfunction

    function automatic logic is_signed_func(intfunc_t f);
        return (f == INT_DIV) || (f == INT_MOD);
    endfunction

    function automatic logic is_mod_func(intfunc_t f);
        return (f == INT_MOD) || (f == INT_MODU);
    endfunction

endpackage

// File: rtl/intdiv_seq_step.sv
// One combinational restoring-division step; kept separate so it can be chained for radix-4.
module intdiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // One guard bit above the remainder so the trial subtract sign is unambiguous
    always_comb begin
        w_shift = {rem_i, q_i[WIDTH-1]};
        w_diff  = w_shift - {2'b00, div_i};
        w_fits  = ~w_diff[WIDTH+1];
        rem_o   = w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
        q_o     = {q_i[WIDTH-2:0], w_fits};
    end

endmodule

// File: rtl/intdiv_seq.sv
// Multicycle radix-2 restoring divider for signed/unsigned divide and modulo.
module intdiv_seq
    import bexkat1Def::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             cancel_i,
    input  intfunc_t         func_i,
    input  logic [WIDTH-1:0] uin1_i,
    input  logic [WIDTH-1:0] uin2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    intdiv_state_t    r_state;
    intfunc_t         r_func;
    logic [CW-1:0]    r_cnt;
    logic             r_s1;
    logic             r_s2;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic             r_done;

    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_bypass;
    logic [WIDTH-1:0] w_imm_res;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    always_comb begin
        w_s1     = is_signed_func(func_i) & uin1_i[WIDTH-1];
        w_s2     = is_signed_func(func_i) & uin2_i[WIDTH-1];
        w_mag1   = w_s1 ? -uin1_i : uin1_i;
        w_mag2   = w_s2 ? -uin2_i : uin2_i;
        w_bypass = (uin2_i == '0) || !is_div_func(func_i);
        // Divide-by-zero: quotient all-ones, remainder is the raw dividend
        if (!is_div_func(func_i)) begin
            w_imm_res = '0;
        end else if (is_mod_func(func_i)) begin
            w_imm_res = uin1_i;
        end else begin
            w_imm_res = '1;
        end
        w_q_fix = (r_s1 ^ r_s2) ? -r_quo : r_quo;
        w_r_fix = r_s1 ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    intdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (r_rem),
        .q_i   (r_quo),
        .div_i (r_div),
        .rem_o (w_rem_nxt),
        .q_o   (w_quo_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_func  <= INT_ADD;
            r_cnt   <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        r_func <= func_i;
                        r_s1   <= w_s1;
                        r_s2   <= w_s2;
                        r_quo  <= w_mag1;
                        r_div  <= w_mag2;
                        r_rem  <= '0;
                        r_cnt  <= CNT_INIT;
                        if (w_bypass) begin
                            r_res   <= w_imm_res;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    if (cancel_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_res   <= is_mod_func(r_func) ? w_r_fix : w_q_fix;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    // A flush in DONE swallows the pulse and leaves out_o untouched
                    if (!cancel_i) begin
                        r_done <= 1'b1;
                        r_out  <= r_res;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = r_done;
    assign out_o  = r_out;

endmodule
